// File: rtl/irq_pending_latch_pkg.sv
// Shared constants and helpers for the interrupt pending latch.
// Optional input synchronizer is enabled with IRQ_PENDING_SYNC_EN.
package irq_pending_latch_pkg;

    localparam int NUM_LINES = 8;
    localparam int ID_W      = 3;

    localparam logic [NUM_LINES-1:0] RESET_MASK_DEFAULT = 8'hFF;

    function automatic logic [NUM_LINES-1:0] id_onehot(
        input logic [ID_W-1:0] id
    );
        logic [NUM_LINES-1:0] r;
        r     = '0;
        r[id] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/irq_pending_latch_priority_encoder.sv
// Fixed-priority encoder: index of the highest set bit.
// Returns 0 for an all-zero input.
module priority_encoder
    import irq_pending_latch_pkg::*;
(
    input  logic [NUM_LINES-1:0] vec,
    output logic [ID_W-1:0]      idx
);

    always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (vec[i]) idx = ID_W'(i);
        end
    end

endmodule

// File: rtl/irq_pending_latch.sv
// Edge-triggered sticky interrupt pending register with mask and ack.
// Define IRQ_PENDING_SYNC_EN to add a two-flop synchronizer on req.
module irq_pending_latch
    import irq_pending_latch_pkg::*;
#(
    parameter logic [NUM_LINES-1:0] RESET_MASK = RESET_MASK_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_LINES-1:0] req,
    input  logic                 mask_wr,
    input  logic [NUM_LINES-1:0] mask_in,
    input  logic                 irq_ack,
    output logic [NUM_LINES-1:0] pending,
    output logic [NUM_LINES-1:0] enc_in,
    output logic                 irq_valid,
    output logic [ID_W-1:0]      irq_id
);

    logic [NUM_LINES-1:0] sampled;

`ifdef IRQ_PENDING_SYNC_EN
    localparam int ARM_LEN = 3;

    logic [NUM_LINES-1:0] sync_q1;
    logic [NUM_LINES-1:0] sync_q2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= req;
            sync_q2 <= sync_q1;
        end
    end

    assign sampled = sync_q2;
`else
    localparam int ARM_LEN = 1;

    assign sampled = req;
`endif

    logic [NUM_LINES-1:0] req_hist;
    logic [NUM_LINES-1:0] mask;
    logic [ARM_LEN-1:0]   arm;
    logic                 armed;
    logic [NUM_LINES-1:0] rise;
    logic                 ack_take;
    logic [NUM_LINES-1:0] ack_clr;
    logic [ID_W-1:0]      enc_id;

    // Edge detection stays off until the history holds a real sample,
    // so lines already high when reset releases do not fire.
    assign armed    = arm[ARM_LEN-1];
    assign rise     = sampled & ~req_hist & {NUM_LINES{armed}};
    assign ack_take = irq_ack & irq_valid;
    assign ack_clr  = ack_take ? id_onehot(irq_id) : '0;
    assign enc_in   = pending & mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm      <= '0;
            req_hist <= '0;
        end else begin
            arm      <= ARM_LEN'({arm, 1'b1});
            req_hist <= sampled;
        end
    end

    // A new edge wins over an ack of the same bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~ack_clr) | rise;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask <= RESET_MASK;
        end else if (mask_wr) begin
            mask <= mask_in;
        end
    end

    priority_encoder u_enc (
        .vec (enc_in),
        .idx (enc_id)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_valid <= 1'b0;
            irq_id    <= '0;
        end else begin
            irq_valid <= |enc_in;
            irq_id    <= enc_id;
        end
    end

endmodule

// File: tb/tb_irq_pending_latch.sv
// Scoreboard bench for irq_pending_latch.
// Builds with or without IRQ_PENDING_SYNC_EN.
module tb_irq_pending_latch;

`ifdef IRQ_PENDING_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    typedef enum logic [1:0] {
        S_PEND,
        S_ENC,
        S_VALID,
        S_ID
    } sel_t;

    typedef struct {
        string      tag;
        sel_t       sel;
        logic [7:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] req = '0;
    logic       mask_wr = 1'b0;
    logic [7:0] mask_in = '0;
    logic       irq_ack = 1'b0;
    logic [7:0] pending;
    logic [7:0] enc_in;
    logic       irq_valid;
    logic [2:0] irq_id;

    int   n_run = 0;
    int   n_fail = 0;
    exp_t sb[$];

    irq_pending_latch dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .mask_wr   (mask_wr),
        .mask_in   (mask_in),
        .irq_ack   (irq_ack),
        .pending   (pending),
        .enc_in    (enc_in),
        .irq_valid (irq_valid),
        .irq_id    (irq_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input sel_t sel,
                        input logic [7:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic score();
        exp_t e;
        logic [7:0] got;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            unique case (e.sel)
                S_PEND:  got = pending;
                S_ENC:   got = enc_in;
                S_VALID: got = {7'd0, irq_valid};
                default: got = {5'd0, irq_id};
            endcase
            chk(e.tag, got, e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_irq(input string tag, input logic v,
                              input logic [2:0] id);
        push({tag, "_valid"}, S_VALID, {7'd0, v});
        push({tag, "_id"}, S_ID, {5'd0, id});
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #3;
        push("rst_pend", S_PEND, 8'h00);
        push("rst_enc", S_ENC, 8'h00);
        expect_irq("rst", 1'b0, 3'd0);
        score();
        rst_n = 1'b1;
        repeat (4) tick();

        // single line, held level
        req = 8'h08;
        push("s1_pend", S_PEND, 8'h08);
        push("s1_novalid", S_VALID, 8'h00);
        repeat (LAT + 1) tick();
        score();
        expect_irq("s1", 1'b1, 3'd3);
        tick();
        score();
        irq_ack = 1'b1;
        push("s1_ack_pend", S_PEND, 8'h00);
        tick();
        score();
        irq_ack = 1'b0;
        repeat (4) tick();
        push("s1_hold_pend", S_PEND, 8'h00);
        expect_irq("s1_hold", 1'b0, 3'd0);
        score();
        req = 8'h00;
        tick();

        // lines 0 and 7 together
        req = 8'h81;
        push("s2_pend", S_PEND, 8'h81);
        repeat (LAT + 1) tick();
        score();
        expect_irq("s2_first", 1'b1, 3'd7);
        tick();
        score();
        irq_ack = 1'b1;
        push("s2_ack7_pend", S_PEND, 8'h01);
        tick();
        score();
        irq_ack = 1'b0;
        expect_irq("s2_second", 1'b1, 3'd0);
        tick();
        score();
        irq_ack = 1'b1;
        push("s2_ack0_pend", S_PEND, 8'h00);
        tick();
        score();
        irq_ack = 1'b0;
        expect_irq("s2_empty", 1'b0, 3'd0);
        tick();
        score();
        req = 8'h00;
        tick();

        // masked line latches but is hidden
        mask_in = 8'h7F;
        mask_wr = 1'b1;
        tick();
        mask_wr = 1'b0;
        req = 8'h80;
        push("s3_pend", S_PEND, 8'h80);
        push("s3_enc", S_ENC, 8'h00);
        repeat (LAT + 1) tick();
        score();
        expect_irq("s3_masked", 1'b0, 3'd0);
        tick();
        score();
        mask_in = 8'hFF;
        mask_wr = 1'b1;
        push("s3_unmask_enc", S_ENC, 8'h80);
        push("s3_unmask_lag", S_VALID, 8'h00);
        tick();
        score();
        mask_wr = 1'b0;
        expect_irq("s3_unmask", 1'b1, 3'd7);
        tick();
        score();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        req = 8'h00;
        tick();

        // ack of 5 coincides with new edges on 5 and 2
        req = 8'h20;
        repeat (LAT + 1) tick();
        expect_irq("s4_pre", 1'b1, 3'd5);
        tick();
        score();
        req = 8'h00;
        tick();
        req = 8'h24;
        repeat (LAT) tick();
        irq_ack = 1'b1;
        push("s4_keep_pend", S_PEND, 8'h24);
        tick();
        score();
        irq_ack = 1'b0;
        expect_irq("s4_keep", 1'b1, 3'd5);
        tick();
        score();
        irq_ack = 1'b1;
        push("s4_ack5_pend", S_PEND, 8'h04);
        tick();
        score();
        irq_ack = 1'b0;
        expect_irq("s4_next", 1'b1, 3'd2);
        tick();
        score();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        req = 8'h00;
        tick();
        push("s4_clear_pend", S_PEND, 8'h00);
        expect_irq("s4_clear", 1'b0, 3'd0);
        score();

        // ack ignored when idle, then async reset
        irq_ack = 1'b1;
        push("s5_ign_pend", S_PEND, 8'h00);
        push("s5_ign_valid", S_VALID, 8'h00);
        tick();
        score();
        irq_ack = 1'b0;
        req = 8'hFF;
        push("s5_all_pend", S_PEND, 8'hFF);
        repeat (LAT + 1) tick();
        score();
        expect_irq("s5_all", 1'b1, 3'd7);
        tick();
        score();
        #2 rst_n = 1'b0;
        #1;
        push("s5_rst_pend", S_PEND, 8'h00);
        push("s5_rst_enc", S_ENC, 8'h00);
        expect_irq("s5_rst", 1'b0, 3'd0);
        score();
        #2 rst_n = 1'b1;
        repeat (6) tick();
        push("s5_held_pend", S_PEND, 8'h00);
        expect_irq("s5_held", 1'b0, 3'd0);
        score();
        req = 8'h00;
        tick();
        req = 8'hFF;
        push("s5_rearm_pend", S_PEND, 8'hFF);
        repeat (LAT + 1) tick();
        score();

        // lowest line alone
        rst_n = 1'b0;
        req = 8'h00;
        #2 rst_n = 1'b1;
        repeat (4) tick();
        req = 8'h01;
        push("s6_pend", S_PEND, 8'h01);
        repeat (LAT + 1) tick();
        score();
        expect_irq("s6", 1'b1, 3'd0);
        tick();
        score();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_pending_latch.md
IRQ_PENDING_LATCH -- requirements
Module: irq_pending_latch

Interface
REQ-001 The parameter list SHALL be: RESET_MASK, 8'hFF, mask register value after reset (1 = line enabled).
REQ-002 The block SHALL have a port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have a port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have a port req, input, 8 bits: raw request lines, level-high, bit 7 highest priority.
REQ-005 The block SHALL have a port mask_wr, input, 1 bit: loads mask_in into the mask register.
REQ-006 The block SHALL have a port mask_in, input, 8 bits: new mask value.
REQ-007 The block SHALL have a port irq_ack, input, 1 bit: consumer acknowledges the presented irq_id.
REQ-008 The block SHALL have a port pending, output, 8 bits: registered pending vector, unmasked.
REQ-009 The block SHALL have a port enc_in, output, 8 bits: pending AND mask, combinational, feeding the downstream priority encoder.
REQ-010 The block SHALL have a port irq_valid, output, 1 bit: registered; high when enc_in is non-zero.
REQ-011 The block SHALL have a port irq_id, output, 3 bits: registered index of the highest set bit of enc_in; 0 when irq_valid is low.

Function
REQ-012 The block SHALL detect a rising edge on req[i] when the sampled value is 1 and the previous sample is 0; level-high without an edge sets nothing.
REQ-013 An edge detected at clock edge k SHALL set pending[i] after edge k; irq_valid/irq_id SHALL reflect it after edge k+1 (one-cycle presentation latency).
REQ-014 Pending bits SHALL be sticky: a set bit is cleared only by an accepted acknowledge or by reset.
REQ-015 An acknowledge SHALL be accepted only when irq_ack=1 and irq_valid=1 in the same cycle; it clears pending[irq_id] at that edge. irq_ack with irq_valid=0 SHALL be ignored.
REQ-016 On a simultaneous accepted acknowledge and new edge on the same bit, the bit SHALL remain set (the new event wins).
REQ-017 An acknowledge of bit i SHALL NOT affect any other pending bit, including bits set in the same cycle.
REQ-018 Masked bits SHALL still latch into pending but SHALL NOT appear on enc_in, irq_valid or irq_id; unmasking later SHALL present them.
REQ-019 mask_wr SHALL update the mask at the clock edge; the new mask SHALL affect irq_valid/irq_id from the following edge.
REQ-020 Priority SHALL be fixed: the highest index wins. All eight set -> irq_id=7; only bit 0 set -> irq_id=0 with irq_valid=1.

Reset
REQ-021 While rst_n=0, pending, the edge-history register and any synchronizer flops SHALL be 0, the mask SHALL be RESET_MASK, irq_valid SHALL be 0 and irq_id SHALL be 0, asynchronously.
REQ-022 Reset asserted mid-operation SHALL discard all pending events. After release, a req line already high SHALL NOT create an event until it falls and rises again.

Configuration
REQ-023 With macro IRQ_PENDING_SYNC_EN defined, req SHALL pass through a two-flop synchronizer before edge detection, adding exactly 2 cycles to REQ-013 latency. Without the macro, req SHALL be sampled directly.

Structure
REQ-024 A shared package SHALL hold the line count (8), the id width (3) and the RESET_MASK default constant.
REQ-025 Highest-bit selection SHALL be one sub-module, priority_encoder (8-in/3-out, output 0 for all-zero input), instantiated on enc_in; irq_valid is derived separately as the OR-reduction of enc_in.

Verification
REQ-026 Scenario: reset, then req=8'b0000_1000 held -> pending=8'h08 one edge later; irq_valid=1, irq_id=3 one edge after that; holding req creates no second event after ack.
REQ-027 Scenario: req bits 0 and 7 rise together -> irq_id=7; ack -> irq_id=0, pending=8'h01; ack -> irq_valid=0, irq_id=0.
REQ-028 Scenario: mask_in=8'h7F with mask_wr, then req[7] edge -> pending=8'h80, enc_in=0, irq_valid=0; restore mask to 8'hFF -> irq_id=7.
REQ-029 Scenario: irq_ack for id 5 coincides with a new req[5] edge -> pending[5] stays 1 and irq_valid stays 1.
REQ-030 Scenario: irq_ack=1 with irq_valid=0, then rst_n pulsed low with pending=8'hFF -> nothing changes on the ack; all outputs reach 0 immediately on reset with no clock.
REQ-031 Scenario: repeat REQ-026 with IRQ_PENDING_SYNC_EN defined -> pending is set 2 cycles later than without the macro.
